multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
- Next-generation control core for the RV32I datapath: replaces the single-cycle combinational decode with a multi-cycle FSM.
- The datapath shares one unified memory port with variable latency (req/ready handshake).
- Sits between the datapath (register file, ALU, instruction register, PC) and the memory. Adds a start trigger, halt on EBREAK/ECALL, a memory-timeout fault, and performance counters.

Parameters:
- CNT_WIDTH, 32, width of cycle_count and instret_count.
- MEM_TIMEOUT, 16, maximum cycles mem_req may wait for mem_ready before fault; 0 disables the timeout.
- TO_WIDTH, 5, width of the timeout counter; must satisfy MEM_TIMEOUT < 2**TO_WIDTH.

Ports:
- clk  in  1  core clock
- rst  in  1  synchronous, active-low reset
- trigger  in  1  start pulse; leaves IDLE/HALT
- Instr  in  32  instruction register contents (opcode/funct3/funct7 decoded here)
- Zero  in  1  ALU result == 0
- Lt  in  1  ALU result bit 0 after SLT/SLTU
- mem_ready  in  1  memory completes the current access this cycle
- mem_req  out  1  memory access request
- MemWrite  out  1  access is a write (valid with mem_req)
- AdrSrc  out  1  0 = PC, 1 = ALUOut as memory address
- IRWrite  out  1  latch Instr and OldPC
- PCWrite  out  1  update PC from Result
- RegWrite  out  1  register file write enable
- ALUSrcA  out  2  0 = PC, 1 = OldPC, 2 = rs1
- ALUSrcB  out  2  0 = rs2, 1 = ImmExt, 2 = constant 4
- ALUControl  out  4  ALU operation (pkg encoding)
- ResultSrc  out  2  0 = ALUOut, 1 = Data, 2 = ALUResult, 3 = ImmExt
- ImmSrc  out  3  I/S/B/U/J immediate select
- busy  out  1  high in any state other than IDLE/HALT/FAULT
- halted  out  1  high in HALT
- fault  out  1  high in FAULT (illegal opcode or timeout)
- cycle_count  out  CNT_WIDTH  cycles spent busy
- instret_count  out  CNT_WIDTH  instructions retired

Behaviour:
- Reset (rst == 0 at a clk edge): state = IDLE; counters = 0; timeout counter = 0; all control outputs 0. Control outputs are a Moore decode of state (plus funct3/Zero/Lt in BRANCH).
- States: IDLE, FETCH, DECODE, MEMADR, MEMRD, MEMWB, MEMWR, EXECR, EXECI, ALUWB, BRANCH, JAL, JALR, LUI, AUIPC, HALT, FAULT.
- IDLE/HALT -> FETCH on trigger. FAULT exits only through reset.
- FETCH: mem_req = 1, AdrSrc = 0, ALUSrcA = 0, ALUSrcB = 2, ALUControl = ADD, ResultSrc = 2.
  - Holds until mem_ready. On the ready cycle, IRWrite = 1 and PCWrite = 1, then go to DECODE.
- DECODE: ALUSrcA = 1, ALUSrcB = 1, ALUControl = ADD (branch target precompute). Dispatch on opcode:
  - load/store -> MEMADR
  - OP -> EXECR; OP-IMM -> EXECI
  - BRANCH -> BRANCH
  - JAL -> JAL; JALR -> JALR
  - LUI -> LUI; AUIPC -> AUIPC
  - SYSTEM -> HALT
  - anything else -> FAULT
- MEMADR (rs1 + imm) -> MEMRD for a load, MEMWR for a store.
- MEMRD: mem_req = 1, AdrSrc = 1; hold until mem_ready, then MEMWB.
- MEMWB: ResultSrc = 1, RegWrite = 1, retire, -> FETCH.
- MEMWR: mem_req = 1, MemWrite = 1, AdrSrc = 1; hold until mem_ready, then retire -> FETCH.
- EXECR/EXECI: ALUControl from funct3/funct7. funct7[5] selects SUB vs ADD only in EXECR; funct7[5] selects SRA in both. Then -> ALUWB.
- ALUWB: ResultSrc = 0, RegWrite = 1, retire -> FETCH.
- BRANCH: ALUSrcA = 2, ALUSrcB = 0, ResultSrc = 0.
  - ALUControl = SUB for beq/bne, SLT for blt/bge, SLTU for bltu/bgeu.
  - taken: beq = Zero, bne = !Zero, blt/bltu = Lt, bge/bgeu = !Lt.
  - PCWrite = taken; retire -> FETCH.
  - funct3 010/011 -> FAULT.
- JAL: PCWrite = 1 (ALUOut target), rd = OldPC + 4; JALR computes rs1 + imm first (extra cycle). LUI: ResultSrc = 3. AUIPC: OldPC + imm. All retire -> FETCH.
- Memory timeout: the counter clears on entering any mem_req state and increments each cycle mem_req is high without mem_ready. When it reaches MEM_TIMEOUT (MEM_TIMEOUT != 0) -> FAULT, with no register or PC write.
- mem_req and mem_ready in the same cycle count as an immediate completion (zero wait).
- Counters: cycle_count += 1 every cycle busy == 1; instret_count += 1 on each retire cycle (HALT entry not counted). Both wrap modulo 2**CNT_WIDTH.
- Reset mid-access: state returns to IDLE next edge; mem_req drops; no write issued.
- trigger ignored while busy or in FAULT.

Decomposition:
- Package multicycle_pkg: state enum; opcode constants; ALUControl encodings ADD=0000, SUB=0001, AND=0010, OR=0011, XOR=0100, SLT=0101, SLTU=0110, SLL=0111, SRL=1000, SRA=1001; ImmSrc encodings I=000, S=001, B=010, U=011, J=100.
- One sub-module: alu_decoder (funct3, funct7[5], isOp -> ALUControl), combinational.

Test Plan:
- rst low 2 cycles with trigger high -> IDLE, all outputs 0, counters 0; release, pulse trigger -> FETCH with mem_req = 1 next cycle.
- addi x1,x0,5 with mem_ready tied high -> FETCH, DECODE, EXECI, ALUWB (4 cycles); RegWrite pulses once; instret_count = 1, cycle_count = 4.
- lw with mem_ready delayed 3 cycles in MEMRD -> mem_req held 4 cycles; RegWrite only in MEMWB; instruction takes 8 cycles total.
- beq with Zero = 1 then Zero = 0 -> PCWrite = 1 in BRANCH only for the first; blt with Lt = 1 -> taken.
- MEM_TIMEOUT = 4, mem_ready stuck low in FETCH -> fault = 1 after 4 cycles, busy = 0; trigger ignored until reset.
- ebreak after 3 retired instructions -> halted = 1, instret_count = 3; rst asserted mid-MEMWR -> IDLE next edge, MemWrite = 0.

Source files
------------

// File: rtl/multicycle_pkg.sv
// Shared types and encodings for the multi-cycle RV32I control core.
// States, opcodes, ALU operation codes and immediate selects live here.
package multicycle_pkg;

  typedef enum logic [4:0] {
    S_IDLE, S_FETCH, S_DECODE, S_MEMADR, S_MEMRD, S_MEMWB, S_MEMWR,
    S_EXECR, S_EXECI, S_ALUWB, S_BRANCH, S_JAL, S_JALR, S_LUI, S_AUIPC,
    S_HALT, S_FAULT
  } state_t;

  localparam logic [6:0] OPC_LOAD   = 7'b0000011;
  localparam logic [6:0] OPC_STORE  = 7'b0100011;
  localparam logic [6:0] OPC_OP     = 7'b0110011;
  localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
  localparam logic [6:0] OPC_BRANCH = 7'b1100011;
  localparam logic [6:0] OPC_JAL    = 7'b1101111;
  localparam logic [6:0] OPC_JALR   = 7'b1100111;
  localparam logic [6:0] OPC_LUI    = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
  localparam logic [6:0] OPC_SYSTEM = 7'b1110011;

  localparam logic [3:0] ALU_ADD  = 4'b0000;
  localparam logic [3:0] ALU_SUB  = 4'b0001;
  localparam logic [3:0] ALU_AND  = 4'b0010;
  localparam logic [3:0] ALU_OR   = 4'b0011;
  localparam logic [3:0] ALU_XOR  = 4'b0100;
  localparam logic [3:0] ALU_SLT  = 4'b0101;
  localparam logic [3:0] ALU_SLTU = 4'b0110;
  localparam logic [3:0] ALU_SLL  = 4'b0111;
  localparam logic [3:0] ALU_SRL  = 4'b1000;
  localparam logic [3:0] ALU_SRA  = 4'b1001;

  localparam logic [2:0] IMM_I = 3'b000;
  localparam logic [2:0] IMM_S = 3'b001;
  localparam logic [2:0] IMM_B = 3'b010;
  localparam logic [2:0] IMM_U = 3'b011;
  localparam logic [2:0] IMM_J = 3'b100;

  function automatic logic [2:0] imm_sel(input logic [6:0] opcode);
    logic [2:0] sel;
    sel = IMM_I;
    case (opcode)
      OPC_STORE:          sel = IMM_S;
      OPC_BRANCH:         sel = IMM_B;
      OPC_LUI, OPC_AUIPC: sel = IMM_U;
      OPC_JAL:            sel = IMM_J;
      default:            sel = IMM_I;
    endcase
    return sel;
  endfunction

endpackage

// File: rtl/alu_decoder.sv
// Combinational funct3/funct7 to ALU operation decode for register and
// immediate arithmetic instructions.
module alu_decoder
  import multicycle_pkg::*;
(
  input  logic [2:0] funct3,
  input  logic       funct7b5,
  input  logic       is_op,
  output logic [3:0] alu_control
);

  always_comb begin
    alu_control = ALU_ADD;
    case (funct3)
      // ADDI has no SUB form, so funct7[5] only matters for register ops
      3'b000: alu_control = (is_op && funct7b5) ? ALU_SUB : ALU_ADD;
      3'b001: alu_control = ALU_SLL;
      3'b010: alu_control = ALU_SLT;
      3'b011: alu_control = ALU_SLTU;
      3'b100: alu_control = ALU_XOR;
      3'b101: alu_control = funct7b5 ? ALU_SRA : ALU_SRL;
      3'b110: alu_control = ALU_OR;
      default: alu_control = ALU_AND;
    endcase
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// Multi-cycle RV32I control FSM driving a shared variable-latency memory
// port, with halt/fault handling and busy/retire performance counters.
module multicycle_ctrl
  import multicycle_pkg::*;
#(
  parameter int CNT_WIDTH   = 32,
  parameter int MEM_TIMEOUT = 16,
  parameter int TO_WIDTH    = 5
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 trigger,
  input  logic [31:0]          Instr,
  input  logic                 Zero,
  input  logic                 Lt,
  input  logic                 mem_ready,
  output logic                 mem_req,
  output logic                 MemWrite,
  output logic                 AdrSrc,
  output logic                 IRWrite,
  output logic                 PCWrite,
  output logic                 RegWrite,
  output logic [1:0]           ALUSrcA,
  output logic [1:0]           ALUSrcB,
  output logic [3:0]           ALUControl,
  output logic [1:0]           ResultSrc,
  output logic [2:0]           ImmSrc,
  output logic                 busy,
  output logic                 halted,
  output logic                 fault,
  output logic [CNT_WIDTH-1:0] cycle_count,
  output logic [CNT_WIDTH-1:0] instret_count
);

  state_t              state, next_state;
  logic [TO_WIDTH-1:0] to_cnt;
  logic                retire, timeout_hit, br_taken, br_bad;
  logic [3:0]          exec_op;
  logic [6:0]          opcode;
  logic [2:0]          funct3;
  logic                unused_instr_bits;

  assign opcode = Instr[6:0];
  assign funct3 = Instr[14:12];
  assign unused_instr_bits = ^{Instr[31], Instr[29:15], Instr[11:7]};

  alu_decoder u_alu_decoder (
    .funct3      (funct3),
    .funct7b5    (Instr[30]),
    .is_op       (state == S_EXECR),
    .alu_control (exec_op)
  );

  assign busy   = !(state inside {S_IDLE, S_HALT, S_FAULT});
  assign halted = (state == S_HALT);
  assign fault  = (state == S_FAULT);

  // Fires on the wait cycle that would bring the counter up to MEM_TIMEOUT
  assign timeout_hit = (MEM_TIMEOUT != 0) && !mem_ready &&
                       (to_cnt == TO_WIDTH'(MEM_TIMEOUT - 1));

  always_ff @(posedge clk) begin
    if (!rst) begin
      state         <= S_IDLE;
      cycle_count   <= '0;
      instret_count <= '0;
      to_cnt        <= '0;
    end else begin
      state <= next_state;
      if (busy)   cycle_count   <= cycle_count + CNT_WIDTH'(1);
      if (retire) instret_count <= instret_count + CNT_WIDTH'(1);
      to_cnt <= (mem_req && !mem_ready) ? to_cnt + TO_WIDTH'(1) : '0;
    end
  end

  always_comb begin
    next_state = state;
    retire     = 1'b0;
    mem_req    = 1'b0;
    MemWrite   = 1'b0;
    AdrSrc     = 1'b0;
    IRWrite    = 1'b0;
    PCWrite    = 1'b0;
    RegWrite   = 1'b0;
    ALUSrcA    = 2'd0;
    ALUSrcB    = 2'd0;
    ALUControl = ALU_ADD;
    ResultSrc  = 2'd0;
    ImmSrc     = IMM_I;
    br_taken   = 1'b0;
    br_bad     = 1'b0;

    case (state)
      S_IDLE, S_HALT: if (trigger) next_state = S_FETCH;
      S_FETCH: begin
        mem_req   = 1'b1;
        ALUSrcB   = 2'd2;
        ResultSrc = 2'd2;
        if (mem_ready) begin
          IRWrite    = 1'b1;
          PCWrite    = 1'b1;
          next_state = S_DECODE;
        end else if (timeout_hit) begin
          next_state = S_FAULT;
        end
      end
      S_DECODE: begin
        ALUSrcA = 2'd1;
        ALUSrcB = 2'd1;
        case (opcode)
          OPC_LOAD, OPC_STORE: next_state = S_MEMADR;
          OPC_OP:              next_state = S_EXECR;
          OPC_OPIMM:           next_state = S_EXECI;
          OPC_BRANCH:          next_state = S_BRANCH;
          OPC_JAL:             next_state = S_JAL;
          OPC_JALR:            next_state = S_JALR;
          OPC_LUI:             next_state = S_LUI;
          OPC_AUIPC:           next_state = S_AUIPC;
          OPC_SYSTEM:          next_state = S_HALT;
          default:             next_state = S_FAULT;
        endcase
      end
      S_MEMADR: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        next_state = (opcode == OPC_STORE) ? S_MEMWR : S_MEMRD;
      end
      S_MEMRD: begin
        mem_req = 1'b1;
        AdrSrc  = 1'b1;
        if (mem_ready)        next_state = S_MEMWB;
        else if (timeout_hit) next_state = S_FAULT;
      end
      S_MEMWB: begin
        ResultSrc  = 2'd1;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_MEMWR: begin
        mem_req  = 1'b1;
        MemWrite = 1'b1;
        AdrSrc   = 1'b1;
        if (mem_ready) begin
          retire     = 1'b1;
          next_state = S_FETCH;
        end else if (timeout_hit) begin
          next_state = S_FAULT;
        end
      end
      S_EXECR: begin
        ALUSrcA    = 2'd2;
        ALUControl = exec_op;
        next_state = S_ALUWB;
      end
      S_EXECI: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        ALUControl = exec_op;
        next_state = S_ALUWB;
      end
      S_ALUWB: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_BRANCH: begin
        ALUSrcA = 2'd2;
        case (funct3)
          3'b000: begin ALUControl = ALU_SUB;  br_taken = Zero;  end
          3'b001: begin ALUControl = ALU_SUB;  br_taken = !Zero; end
          3'b100: begin ALUControl = ALU_SLT;  br_taken = Lt;    end
          3'b101: begin ALUControl = ALU_SLT;  br_taken = !Lt;   end
          3'b110: begin ALUControl = ALU_SLTU; br_taken = Lt;    end
          3'b111: begin ALUControl = ALU_SLTU; br_taken = !Lt;   end
          default: br_bad = 1'b1;
        endcase
        if (br_bad) begin
          next_state = S_FAULT;
        end else begin
          PCWrite    = br_taken;
          retire     = 1'b1;
          next_state = S_FETCH;
        end
      end
      // PC takes the target held in ALUOut while OldPC+4 is formed for rd
      S_JAL: begin
        ALUSrcA    = 2'd1;
        ALUSrcB    = 2'd2;
        PCWrite    = 1'b1;
        next_state = S_ALUWB;
      end
      S_JALR: begin
        ALUSrcA    = 2'd2;
        ALUSrcB    = 2'd1;
        next_state = S_JAL;
      end
      S_LUI: begin
        ResultSrc  = 2'd3;
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_AUIPC: begin
        RegWrite   = 1'b1;
        retire     = 1'b1;
        next_state = S_FETCH;
      end
      S_FAULT: next_state = S_FAULT;
      default: next_state = S_IDLE;
    endcase

    if (!(state inside {S_IDLE, S_FETCH, S_HALT, S_FAULT})) ImmSrc = imm_sel(opcode);
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Self-checking bench: directed and random instructions against an
// instruction-level cycle/strobe model of the control core.
module tb_multicycle_ctrl;
  import multicycle_pkg::*;

  logic        clk = 1'b0;
  logic        rst = 1'b0;
  logic        trigger = 1'b0;
  logic [31:0] Instr = 32'h0;
  logic        Zero = 1'b0;
  logic        Lt = 1'b0;
  logic        mem_ready = 1'b0;
  logic        mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite;
  logic [1:0]  ALUSrcA, ALUSrcB, ResultSrc;
  logic [3:0]  ALUControl;
  logic [2:0]  ImmSrc;
  logic        busy, halted, fault;
  logic [31:0] cycle_count, instret_count;

  int tests = 0;
  int fails = 0;
  int m_cycles = 0;
  int m_instret = 0;

  multicycle_ctrl #(.CNT_WIDTH(32), .MEM_TIMEOUT(4), .TO_WIDTH(5)) dut (
    .clk(clk), .rst(rst), .trigger(trigger), .Instr(Instr), .Zero(Zero), .Lt(Lt),
    .mem_ready(mem_ready), .mem_req(mem_req), .MemWrite(MemWrite), .AdrSrc(AdrSrc),
    .IRWrite(IRWrite), .PCWrite(PCWrite), .RegWrite(RegWrite), .ALUSrcA(ALUSrcA),
    .ALUSrcB(ALUSrcB), .ALUControl(ALUControl), .ResultSrc(ResultSrc), .ImmSrc(ImmSrc),
    .busy(busy), .halted(halted), .fault(fault), .cycle_count(cycle_count),
    .instret_count(instret_count)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_trigger();
    trigger = 1'b1;
    tick();
    trigger = 1'b0;
  endtask

  task automatic do_reset();
    rst = 1'b0;
    tick();
    rst = 1'b1;
    m_cycles  = 0;
    m_instret = 0;
  endtask

  function automatic logic [3:0] alu_ref(input logic [2:0] f3, input logic b5, input logic isr);
    logic [3:0] r;
    r = ALU_ADD;
    case (f3)
      3'd0: r = (isr && b5) ? ALU_SUB : ALU_ADD;
      3'd1: r = ALU_SLL;
      3'd2: r = ALU_SLT;
      3'd3: r = ALU_SLTU;
      3'd4: r = ALU_XOR;
      3'd5: r = b5 ? ALU_SRA : ALU_SRL;
      3'd6: r = ALU_OR;
      default: r = ALU_AND;
    endcase
    return r;
  endfunction

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [9] = '{7'b0000011, 7'b0100011, 7'b0110011, 7'b0010011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111, 7'b0010111};
    logic [2:0] bf3 [6] = '{3'd0, 3'd1, 3'd4, 3'd5, 3'd6, 3'd7};
    logic [31:0] r;
    int k;
    r = $urandom();
    k = int'($urandom_range(0, 8));
    r[6:0] = ops[k];
    if (k == 4) r[14:12] = bf3[$urandom_range(0, 5)];
    return r;
  endfunction

  // Runs one instruction from FETCH; fw/mw are wait cycles before mem_ready
  task automatic exec_instr(input string tag, input logic [31:0] ins, input int fw,
                            input int mw, input logic zero, input logic lt);
    logic [6:0] opc;
    logic [2:0] f3;
    bit ld, st, opr, opi, br, jl, jlr, lui, aui, sys, taken, wr;
    int body, total, n_rw, n_pcw, n_mw, n_req, rw_last, busy_bad;
    opc = ins[6:0];
    f3  = ins[14:12];
    ld  = (opc == 7'b0000011); st  = (opc == 7'b0100011);
    opr = (opc == 7'b0110011); opi = (opc == 7'b0010011);
    br  = (opc == 7'b1100011); jl  = (opc == 7'b1101111);
    jlr = (opc == 7'b1100111); lui = (opc == 7'b0110111);
    aui = (opc == 7'b0010111); sys = (opc == 7'b1110011);
    taken = 1'b0;
    if (br) begin
      case (f3)
        3'd0: taken = zero;
        3'd1: taken = !zero;
        3'd4, 3'd6: taken = lt;
        3'd5, 3'd7: taken = !lt;
        default: taken = 1'b0;
      endcase
    end
    if (ld)               body = mw + 3;
    else if (st)          body = mw + 2;
    else if (opr || opi)  body = 2;
    else if (br)          body = 1;
    else if (jl)          body = 2;
    else if (jlr)         body = 3;
    else if (lui || aui)  body = 1;
    else                  body = 0;
    total = fw + 2 + body;
    wr = ld || opr || opi || jl || jlr || lui || aui;
    n_rw = 0; n_pcw = 0; n_mw = 0; n_req = 0; rw_last = -1; busy_bad = 0;
    for (int c = 0; c < total; c++) begin
      mem_ready = (c == fw) || ((ld || st) && c == fw + 3 + mw);
      Zero = zero;
      Lt   = lt;
      if (c == fw + 1) Instr = ins;
      #1;
      if (RegWrite) begin n_rw++; rw_last = c; end
      if (PCWrite)  n_pcw++;
      if (MemWrite) n_mw++;
      if (mem_req)  n_req++;
      if (busy !== 1'b1) busy_bad++;
      if ((opr || opi) && c == fw + 2)
        check({tag, " alu_op"}, 32'(ALUControl), 32'(alu_ref(f3, ins[30], opr)));
      if (br && c == fw + 2) check({tag, " br_pcwrite"}, 32'(PCWrite), 32'(taken));
      @(posedge clk);
      #1;
    end
    mem_ready = 1'b0;
    m_cycles += total;
    if (!sys) m_instret++;
    check({tag, " regwrite_n"}, 32'(n_rw), 32'(wr));
    if (wr) check({tag, " regwrite_at"}, 32'(rw_last), 32'(total - 1));
    check({tag, " pcwrite_n"}, 32'(n_pcw), 32'(1 + int'(taken) + int'(jl || jlr)));
    check({tag, " memwrite_n"}, 32'(n_mw), 32'(st ? mw + 1 : 0));
    check({tag, " memreq_n"}, 32'(n_req), 32'(fw + 1 + ((ld || st) ? mw + 1 : 0)));
    check({tag, " busy"}, 32'(busy_bad), 32'd0);
    check({tag, " cycle_count"}, cycle_count, 32'(m_cycles));
    check({tag, " instret"}, instret_count, 32'(m_instret));
    check({tag, " halted"}, 32'(halted), 32'(sys));
  endtask

  initial begin
    // Reset with trigger held high
    rst = 1'b0;
    trigger = 1'b1;
    tick();
    tick();
    check("rst outputs", 32'({mem_req, MemWrite, AdrSrc, IRWrite, PCWrite, RegWrite, ALUSrcA,
          ALUSrcB, ALUControl, ResultSrc, ImmSrc, busy, halted, fault}), 32'd0);
    check("rst cycle_count", cycle_count, 32'd0);
    check("rst instret", instret_count, 32'd0);
    trigger = 1'b0;
    rst = 1'b1;
    tick();
    check("idle busy", 32'(busy), 32'd0);
    pulse_trigger();
    check("start mem_req", 32'(mem_req), 32'd1);
    check("start busy", 32'(busy), 32'd1);

    exec_instr("addi", 32'h00500093, 0, 0, 1'b0, 1'b0);
    check("addi cycles", cycle_count, 32'd4);
    exec_instr("lw", 32'h0000A103, 0, 3, 1'b0, 1'b0);
    exec_instr("beq_t", 32'h00000063, 1, 0, 1'b1, 1'b0);
    exec_instr("ebreak", 32'h00100073, 0, 0, 1'b0, 1'b0);
    check("halt instret", instret_count, 32'd3);
    check("halt busy", 32'(busy), 32'd0);
    pulse_trigger();
    check("resume mem_req", 32'(mem_req), 32'd1);

    exec_instr("beq_nt", 32'h00000063, 0, 0, 1'b0, 1'b1);
    exec_instr("blt_t", 32'h00004063, 2, 0, 1'b0, 1'b1);
    trigger = 1'b1;
    exec_instr("sub_trig", 32'h40208033, 0, 0, 1'b0, 1'b0);
    trigger = 1'b0;
    exec_instr("sw", 32'h0020A023, 0, 2, 1'b0, 1'b0);
    for (int i = 0; i < 40; i++)
      exec_instr("rnd", rand_instr(), int'($urandom_range(0, 2)), int'($urandom_range(0, 3)),
                 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)));

    // Reset while a store is waiting on memory
    mem_ready = 1'b1;
    tick();
    Instr = 32'h0020A023;
    mem_ready = 1'b0;
    tick();
    tick();
    check("memwr active", 32'(MemWrite), 32'd1);
    rst = 1'b0;
    tick();
    check("midrst memwrite", 32'(MemWrite), 32'd0);
    check("midrst mem_req", 32'(mem_req), 32'd0);
    check("midrst busy", 32'(busy), 32'd0);
    check("midrst cycles", cycle_count, 32'd0);
    rst = 1'b1;
    m_cycles = 0;
    m_instret = 0;

    // Fetch timeout with memory never answering
    pulse_trigger();
    tick();
    tick();
    tick();
    check("to pre fault", 32'(fault), 32'd0);
    tick();
    check("to fault", 32'(fault), 32'd1);
    check("to busy", 32'(busy), 32'd0);
    pulse_trigger();
    check("to trig ignored", 32'(fault), 32'd1);
    check("to no req", 32'(mem_req), 32'd0);

    // Illegal opcode
    do_reset();
    pulse_trigger();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    Instr = 32'h0000007F;
    tick();
    check("illegal opc fault", 32'(fault), 32'd1);
    check("illegal opc instret", instret_count, 32'd0);

    // Branch with reserved funct3
    do_reset();
    pulse_trigger();
    mem_ready = 1'b1;
    tick();
    mem_ready = 1'b0;
    Instr = 32'h00002063;
    tick();
    check("bad br pcwrite", 32'(PCWrite), 32'd0);
    tick();
    check("bad br fault", 32'(fault), 32'd1);
    check("bad br instret", instret_count, 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
